seg_pipe_adder: RTL and testbench
=================================

# seg_pipe_adder

Parametrised, pipelined, multi-channel add/subtract unit. Operands of width N are split into SEG-bit slices, and one slice is resolved per pipeline stage with the carry registered between stages, so the carry chain per cycle is only SEG bits. Each transaction carries a channel tag, which lets one instance serve several independent adder users in place of separate per-width instances. Sits between operand producers and consumers on valid/ready streams, with full backpressure.

## Interface
- N, 8, operand width in bits (N ≥ 1)
- SEG, 4, slice width per pipeline stage (1 ≤ SEG ≤ N)
- TAGW, 2, channel tag width (TAGW ≥ 1)
- Derived STAGES = ceil(N/SEG); the last slice is N − (STAGES−1)·SEG bits wide.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand transaction present
- in_ready  out  1  unit accepts this cycle
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_sub  in  1  0: A+B, 1: A−B
- in_tag  in  TAGW  channel tag, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_sum  out  N+1  result; see Operation
- out_tag  out  TAGW  tag of the result

## Operation
- Add: out_sum = zero-extended A + B, where bit N is the carry-out.
- Sub: out_sum[N−1:0] = A + ~B + 1 mod 2^N. out_sum[N] = carry-out, so 1 means A ≥ B (unsigned) and 0 means borrow.
- Stage i (0-based) adds slice i of A and B′ (B′ = B or ~B) plus the incoming carry. The carry-in of stage 0 is in_sub.
- Each stage register holds:
  - the resolved low slices,
  - the unresolved high slices of A and B′ (skew buffer),
  - the carry, tag and a valid bit.
- The final stage register drives out_sum, out_tag and out_valid directly.
- Global stall: en = !out_valid || out_ready, and in_ready = en. When en = 0, all stage registers hold.
- An accept occurs when in_valid && in_ready. When en = 1 and there is no accept, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed.
- Tags are never interpreted. Ordering is strictly FIFO across all tags.

## Timing
- Reset (async assert, sync release): every stage valid = 0, so out_valid = 0 and in_ready = 1. out_sum = 0 and out_tag = 0.
- Latency: a transaction accepted at edge k appears on the outputs after edge k+STAGES−1, provided there are no stalls. For STAGES = 1 it appears right after the accepting edge.
- Throughput: 1 transaction per cycle while out_ready = 1.
- in_ready is a combinational function of out_valid and out_ready only. It never depends on in_valid.
- While out_valid = 1 and out_ready = 0: out_sum and out_tag stay stable, and no accept occurs.
- Simultaneous output handshake and input accept in the same cycle is legal and must not lose or duplicate data.
- Reset asserted mid-operation: all in-flight transactions are discarded immediately and no partial result is emitted. After release the unit behaves as from power-up.
- Wrap-around: A+B with a carry out of bit N−1 sets out_sum[N]. There is no saturation.

## Structure
- Shared package seg_pipe_pkg:
  - function num_stages(N, SEG)
  - function slice_width(i, N, SEG)
  - op-mode constants OP_ADD = 0 and OP_SUB = 1
- Sub-module add_slice_stage:
  - one stage, parametrised by slice width and by the remaining skew width;
  - has a slice adder and a pipeline register with enable;
  - instantiated STAGES times with a generate loop.
- Top level holds only the stall logic and the B inversion.

## Test plan
- N=8, SEG=4, add 0xFF+0x01, tag 2, out_ready=1 → out_sum=0x100 and out_tag=2 after edge k+1. in_ready stays 1 throughout.
- N=8, SEG=4, sub 0x05−0x07 → out_sum=0x0FE (bit 8 = 0). Sub 0x07−0x05 → 0x102.
- N=5, SEG=2 (STAGES=3, last slice 1 bit):
  - 31+31 → 62 (0x3E) after edge k+2;
  - back-to-back stream of 0+0, 1+1, …, 9+9 → results 0, 2, …, 18 in order on consecutive cycles.
- Backpressure: stream 4 transactions while holding out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 for exactly those cycles.
  - out_sum and out_tag are held stable.
  - All 4 results arrive in order, with none lost or duplicated.
- Reset mid-flight: assert rst with 2 transactions in the pipe.
  - out_valid=0 and out_sum=0 immediately (asynchronously).
  - After release, no stale result appears, and a fresh 3+4 returns 7.
- Degenerate N=8, SEG=8 (STAGES=1) → 0x80+0x80 = 0x100 right after the accepting edge, with full throughput under randomized out_ready.

Source files
------------

// File: rtl/seg_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the segmented pipelined adder.
// Stage count and per-stage slice widths are derived here so every file agrees on them.
package seg_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int num_stages(input int n, input int seg);
        return (n + seg - 1) / seg;
    endfunction

    // Every slice is SEG wide except the last, which takes whatever bits remain.
    function automatic int slice_width(input int i, input int n, input int seg);
        if (i < num_stages(n, seg) - 1) begin
            return seg;
        end
        return n - (num_stages(n, seg) - 1) * seg;
    endfunction

endpackage

// File: rtl/add_slice_stage.sv
// One pipeline stage: resolves one SW-bit slice of A + B' + carry and forwards the
// still-unresolved high bits of A and B' (the skew buffer) plus the new carry.
module add_slice_stage #(
    parameter int N      = 8,
    parameter int TAGW   = 2,
    parameter int LO     = 0,
    parameter int SW     = 4,
    parameter int SKEW_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         valid_i,
    input  logic [TAGW-1:0]              tag_i,
    input  logic [N-1:0]                 res_i,
    input  logic [2*(SW+SKEW_W):0]       fwd_i,
    output logic                         valid_o,
    output logic [TAGW-1:0]              tag_o,
    output logic [N-1:0]                 res_o,
    output logic [2*SKEW_W:0]            fwd_o
);

    // fwd bus layout: {a[W_IN-1:0], b'[W_IN-1:0], carry}
    localparam int W_IN = SW + SKEW_W;

    logic [SW-1:0]     a_slice;
    logic [SW-1:0]     b_slice;
    logic              carry_in;
    logic [SW:0]       slice_sum;
    logic [N-1:0]      res_d;
    logic [N-1:0]      res_q;
    logic [2*SKEW_W:0] fwd_d;
    logic [2*SKEW_W:0] fwd_q;
    logic              valid_q;
    logic [TAGW-1:0]   tag_q;

    assign a_slice   = fwd_i[W_IN+1 +: SW];
    assign b_slice   = fwd_i[1 +: SW];
    assign carry_in  = fwd_i[0];
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SW{1'b0}}, carry_in};

    always_comb begin
        res_d             = res_i;
        res_d[LO +: SW]   = slice_sum[SW-1:0];
    end

    if (SKEW_W > 0) begin : g_skew
        assign fwd_d = {fwd_i[2*W_IN -: SKEW_W], fwd_i[W_IN -: SKEW_W], slice_sum[SW]};
    end else begin : g_last
        assign fwd_d = slice_sum[SW];
    end

    // NOTE: sequential state uses non-blocking assignments, and every register (data
    // included) is cleared on reset so the outputs read zero while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            fwd_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            tag_q   <= tag_i;
            res_q   <= res_d;
            fwd_q   <= fwd_d;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign res_o   = res_q;
    assign fwd_o   = fwd_q;

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined multi-channel add/subtract: one SEG-bit slice resolved per stage, carry
// registered between stages, global stall driven from the output handshake.
module seg_pipe_adder
    import seg_pipe_pkg::*;
#(
    parameter int N    = 8,
    parameter int SEG  = 4,
    parameter int TAGW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic            in_sub,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N:0]      out_sum,
    output logic [TAGW-1:0] out_tag
);

    localparam int STAGES = num_stages(N, SEG);

    logic            en;
    logic [N-1:0]    b_eff;
    logic            valid_c [STAGES+1];
    logic [TAGW-1:0] tag_c   [STAGES+1];
    logic [N-1:0]    res_c   [STAGES+1];

    // Stall the whole pipe only when a result is waiting and the consumer refuses it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in of stage 0.
    assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;

    assign valid_c[0] = in_valid && en;
    assign tag_c[0]   = in_tag;
    assign res_c[0]   = '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO     = s * SEG;
        localparam int SW     = slice_width(s, N, SEG);
        localparam int SKEW_W = N - LO - SW;

        logic [2*(SW+SKEW_W):0] fwd_in;
        logic [2*SKEW_W:0]      fwd_out;

        if (s == 0) begin : g_first
            assign fwd_in = {in_a, b_eff, in_sub};
        end else begin : g_next
            assign fwd_in = g_stage[s-1].fwd_out;
        end

        add_slice_stage #(
            .N      (N),
            .TAGW   (TAGW),
            .LO     (LO),
            .SW     (SW),
            .SKEW_W (SKEW_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .valid_i (valid_c[s]),
            .tag_i   (tag_c[s]),
            .res_i   (res_c[s]),
            .fwd_i   (fwd_in),
            .valid_o (valid_c[s+1]),
            .tag_o   (tag_c[s+1]),
            .res_o   (res_c[s+1]),
            .fwd_o   (fwd_out)
        );
    end

    // The last stage has no skew left, so its forward bus is just the final carry.
    assign out_valid = valid_c[STAGES];
    assign out_tag   = tag_c[STAGES];
    assign out_sum   = {g_stage[STAGES-1].fwd_out[0], res_c[STAGES]};

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: three configurations (8/4, 5/2, 8/8) share
// one stimulus driver and one scoreboard; only the selected instance is active.
module tb_seg_pipe_adder;

    typedef struct packed {
        logic [8:0] sum;
        logic [1:0] tag;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [1:0] tag;
        logic [8:0] sum;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic       rdy = 1'b1;
    logic       sub_drv = 1'b0;
    logic [7:0] a_drv = '0;
    logic [7:0] b_drv = '0;
    logic [1:0] tag_drv = '0;
    int         sel = 0;

    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // Instance 0: N=8 SEG=4 (2 stages)
    logic       iv0, ir0, ov0, or0;
    logic [8:0] os0;
    logic [1:0] ot0;
    // Instance 1: N=5 SEG=2 (3 stages, last slice 1 bit)
    logic       iv1, ir1, ov1, or1;
    logic [5:0] os1;
    logic [1:0] ot1;
    // Instance 2: N=8 SEG=8 (1 stage)
    logic       iv2, ir2, ov2, or2;
    logic [8:0] os2;
    logic [1:0] ot2;

    assign iv0 = vld && (sel == 0);
    assign iv1 = vld && (sel == 1);
    assign iv2 = vld && (sel == 2);
    assign or0 = (sel == 0) ? rdy : 1'b1;
    assign or1 = (sel == 1) ? rdy : 1'b1;
    assign or2 = (sel == 2) ? rdy : 1'b1;

    seg_pipe_adder #(.N(8), .SEG(4), .TAGW(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(a_drv), .in_b(b_drv),
        .in_sub(sub_drv), .in_tag(tag_drv), .out_valid(ov0), .out_ready(or0),
        .out_sum(os0), .out_tag(ot0)
    );

    seg_pipe_adder #(.N(5), .SEG(2), .TAGW(2)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(a_drv[4:0]),
        .in_b(b_drv[4:0]), .in_sub(sub_drv), .in_tag(tag_drv), .out_valid(ov1),
        .out_ready(or1), .out_sum(os1), .out_tag(ot1)
    );

    seg_pipe_adder #(.N(8), .SEG(8), .TAGW(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(a_drv), .in_b(b_drv),
        .in_sub(sub_drv), .in_tag(tag_drv), .out_valid(ov2), .out_ready(or2),
        .out_sum(os2), .out_tag(ot2)
    );

    logic       ov_s, ir_s, or_s;
    logic [8:0] sum_s;
    logic [1:0] tag_s;

    always_comb begin
        ov_s  = ov0;
        ir_s  = ir0;
        or_s  = or0;
        sum_s = os0;
        tag_s = ot0;
        case (sel)
            1: begin ov_s = ov1; ir_s = ir1; or_s = or1; sum_s = {3'b000, os1}; tag_s = ot1; end
            2: begin ov_s = ov2; ir_s = ir2; or_s = or2; sum_s = os2; tag_s = ot2; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: subtraction as A + 2^n - B, which lands bit n on "A >= B".
    function automatic logic [8:0] model(input int n, input logic [7:0] a, input logic [7:0] b,
                                         input logic sub);
        int unsigned m  = (32'd1 << n) - 1;
        int unsigned aa = a & m;
        int unsigned bb = b & m;
        if (sub) return 9'(aa + (32'd1 << n) - bb);
        return 9'(aa + bb);
    endfunction

    // Scoreboard consumer: every output handshake must match the oldest accepted request.
    always @(negedge clk) begin
        if (!rst && ov_s && or_s) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_result", 32'(ov_s), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("out_sum", 32'(sum_s), 32'(mon_e.sum));
                check("out_tag", 32'(tag_s), 32'(mon_e.tag));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [1:0] tag, input logic [8:0] exp_sum);
        vld = 1'b1; a_drv = a; b_drv = b; sub_drv = sub; tag_drv = tag;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ir_s) begin
                q.push_back('{sum: exp_sum, tag: tag});
                @(posedge clk); #1;
                vld = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Counts extra edges after the accepting edge until out_valid rises.
    task automatic latency(input string name, input int exp_edges);
        int n = 0;
        while (!ov_s && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n), 32'(exp_edges));
    endtask

    vec_t       vecs[10];
    logic [8:0] held_sum;
    logic [1:0] held_tag;
    int         n0;
    logic       done;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 2'd2, 9'h100};
        vecs[1] = '{8'h05, 8'h07, 1'b1, 2'd1, 9'h0FE};
        vecs[2] = '{8'h07, 8'h05, 1'b1, 2'd3, 9'h102};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 2'd0, 9'h000};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 2'd2, 9'h101};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 2'd1, 9'h0FF};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 2'd3, 9'h100};
        vecs[7] = '{8'h00, 8'h01, 1'b1, 2'd0, 9'h0FF};
        vecs[8] = '{8'hC3, 8'h3C, 0, 2'd2, 9'h0FF};
        vecs[9] = '{8'hFF, 8'hFF, 0, 2'd1, 9'h1FE};

        // Reset state, all three configurations
        #2;
        check("rst_valid8", 32'(ov0), 0); check("rst_ready8", 32'(ir0), 1);
        check("rst_sum8", 32'(os0), 0);   check("rst_tag8", 32'(ot0), 0);
        check("rst_valid5", 32'(ov1), 0); check("rst_ready5", 32'(ir1), 1);
        check("rst_sum5", 32'(os1), 0);   check("rst_tag5", 32'(ot1), 0);
        check("rst_valid1", 32'(ov2), 0); check("rst_ready1", 32'(ir2), 1);
        check("rst_sum1", 32'(os2), 0);   check("rst_tag1", 32'(ot2), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // N=8 SEG=4: wrap-around add, latency one extra edge
        sel = 0;
        send(8'hFF, 8'h01, 1'b0, 2'd2, 9'h100);
        check("in_ready_idle8", 32'(ir_s), 1);
        latency("latency_stages2", 1);
        drain();

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].tag, vecs[i].sum);
        end
        drain();

        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra = 8'($urandom);
            logic [7:0] rb = 8'($urandom);
            logic       rs = 1'($urandom);
            send(ra, rb, rs, 2'(i), model(8, ra, rb, rs));
        end
        drain();

        // Backpressure: out_ready low for 3 cycles while a result is waiting
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(8'(16 * i + 1), 8'(i + 2), 1'b0, 2'(i), 9'(17 * i + 3));
                end
            end
            begin
                @(posedge clk); @(posedge clk); #1;
                rdy = 1'b0;
                held_sum = sum_s;
                held_tag = tag_s;
                check("bp_valid", 32'(ov_s), 1);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(ir_s), 0);
                    check("bp_sum_stable", 32'(sum_s), 32'(held_sum));
                    check("bp_tag_stable", 32'(tag_s), 32'(held_tag));
                    @(posedge clk); #1;
                end
                rdy = 1'b1;
                @(negedge clk);
                check("bp_in_ready_back", 32'(ir_s), 1);
            end
        join
        drain();
        check("bp_result_count", 32'(n_out - n0), 4);

        // Reset with two transactions in flight
        send(8'h01, 8'h02, 1'b0, 2'd1, 9'h003);
        send(8'h03, 8'h04, 1'b0, 2'd2, 9'h007);
        check("pre_rst_valid", 32'(ov0), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(ov0), 0);
        check("async_rst_sum", 32'(os0), 0);
        check("async_rst_ready", 32'(ir0), 1);
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_stale_result", 32'(ov_s), 0);
        end
        @(posedge clk); #1;
        send(8'h03, 8'h04, 1'b0, 2'd1, 9'h007);
        drain();

        // N=5 SEG=2: last slice 1 bit, latency two extra edges
        sel = 1;
        send(8'd31, 8'd31, 1'b0, 2'd3, 9'h03E);
        latency("latency_stages3", 2);
        drain();

        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(8'(i), 8'(i), 1'b0, 2'(i), 9'(2 * i));
                end
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!ov_s && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                for (int c = 0; c < 10; c++) begin
                    check("stream5_back_to_back", 32'(ov_s), 1);
                    @(negedge clk);
                end
            end
        join
        drain();

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra = 8'($urandom);
            logic [7:0] rb = 8'($urandom);
            logic       rs = 1'($urandom);
            send(ra, rb, rs, 2'(i), model(5, ra, rb, rs));
        end
        drain();

        // N=8 SEG=8: single stage, result right after the accepting edge
        sel = 2;
        send(8'h80, 8'h80, 1'b0, 2'd2, 9'h100);
        latency("latency_stages1", 0);
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [7:0] ra = 8'($urandom);
                    logic [7:0] rb = 8'($urandom);
                    logic       rs = 1'($urandom);
                    send(ra, rb, rs, 2'(i), model(8, ra, rb, rs));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rdy = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check("in_ready_comb", 32'(ir_s), 32'(!ov_s || or_s));
                end
            end
        join
        rdy = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
